// File: rtl/contador_modulo_n_pkg.sv
// ============================================================================
// contador_pkg : shared direction and mode encodings for the modulo-N counter
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package contador_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_t;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

endpackage

`default_nettype wire

// File: rtl/contador_modulo_n_grupos.sv
// ============================================================================
// contador_grupos : saturating up/down tally of completed groups
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module contador_grupos #(
    parameter int GWIDTH = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              inc,
    input  logic              dec,
    input  logic              clr,
    output logic [GWIDTH-1:0] groups,
    output logic              groups_full
);

    logic [GWIDTH-1:0] r_groups;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_groups <= '0;
        end else if (clr) begin
            r_groups <= '0;
        end else if (inc && (r_groups != '1)) begin
            r_groups <= r_groups + 1'b1;
        end else if (dec && (r_groups != '0)) begin
            r_groups <= r_groups - 1'b1;
        end
    end

    assign groups      = r_groups;
    assign groups_full = (r_groups == '1);

endmodule

`default_nettype wire

// File: rtl/contador_modulo_n.sv
// ============================================================================
// contador_modulo_n : modulo-N up/down event counter with group accumulation
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module contador_modulo_n
    import contador_pkg::*;
#(
    parameter int MODULO   = 12,
    parameter int WIDTH    = 4,
    parameter int GWIDTH   = 8,
    parameter int SATURATE = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              up_down,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_value,
    input  logic              clear,
    output logic [WIDTH-1:0]  count,
    output logic [GWIDTH-1:0] groups,
    output logic              wrap,
    output logic              groups_full
);

    localparam logic [WIDTH-1:0] c_max = WIDTH'(MODULO - 1);

    generate
        if ((MODULO < 2) || ((2 ** WIDTH) < MODULO)) begin : g_bad_params
            $error("contador_modulo_n: need MODULO >= 2 and 2**WIDTH >= MODULO");
        end
    endgenerate

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic [WIDTH-1:0] w_count_next;
    logic             w_wrap_next;
    logic             w_inc;
    logic             w_dec;

    always_comb begin
        w_count_next = r_count;
        w_wrap_next  = 1'b0;
        w_inc        = 1'b0;
        w_dec        = 1'b0;
        if (clear) begin
            w_count_next = '0;
        end else if (load) begin
            // Out-of-range loads clamp so count stays inside 0..MODULO-1
            w_count_next = (load_value > c_max) ? c_max : load_value;
        end else if (enable) begin
            if (up_down == DIR_UP) begin
                if (r_count < c_max) begin
                    w_count_next = r_count + 1'b1;
                end else if (SATURATE == MODE_WRAP) begin
                    w_count_next = '0;
                    w_wrap_next  = 1'b1;
                    w_inc        = 1'b1;
                end
            end else begin
                if (r_count != '0) begin
                    w_count_next = r_count - 1'b1;
                end else if (SATURATE == MODE_WRAP) begin
                    w_count_next = c_max;
                    w_wrap_next  = 1'b1;
                    w_dec        = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_wrap  <= w_wrap_next;
        end
    end

    contador_grupos #(
        .GWIDTH (GWIDTH)
    ) u_grupos (
        .clock       (clock),
        .reset       (reset),
        .inc         (w_inc),
        .dec         (w_dec),
        .clr         (clear),
        .groups      (groups),
        .groups_full (groups_full)
    );

    assign count = r_count;
    assign wrap  = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_contador_modulo_n.sv
// ============================================================================
// tb_contador_modulo_n : directed checks on wrap, small-group and saturate builds
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_contador_modulo_n;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       up_down;
    logic       load;
    logic [3:0] load_value;
    logic       clear;

    logic [3:0] cnt0, cnt1, cnt2;
    logic [7:0] grp0, grp2;
    logic [1:0] grp1;
    logic       wrap0, wrap1, wrap2;
    logic       full0, full1, full2;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    contador_modulo_n #(.MODULO(12), .WIDTH(4), .GWIDTH(8), .SATURATE(0)) u_wrap (
        .clock(clock), .reset(reset), .enable(enable), .up_down(up_down),
        .load(load), .load_value(load_value), .clear(clear),
        .count(cnt0), .groups(grp0), .wrap(wrap0), .groups_full(full0)
    );

    contador_modulo_n #(.MODULO(12), .WIDTH(4), .GWIDTH(2), .SATURATE(0)) u_small (
        .clock(clock), .reset(reset), .enable(enable), .up_down(up_down),
        .load(load), .load_value(load_value), .clear(clear),
        .count(cnt1), .groups(grp1), .wrap(wrap1), .groups_full(full1)
    );

    contador_modulo_n #(.MODULO(12), .WIDTH(4), .GWIDTH(8), .SATURATE(1)) u_sat (
        .clock(clock), .reset(reset), .enable(enable), .up_down(up_down),
        .load(load), .load_value(load_value), .clear(clear),
        .count(cnt2), .groups(grp2), .wrap(wrap2), .groups_full(full2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset      = 1'b0;
        enable     = 1'b0;
        up_down    = 1'b1;
        load       = 1'b0;
        load_value = 4'd0;
        clear      = 1'b0;
        #2;
        check("rst_count", 32'(cnt0), 0);
        check("rst_groups", 32'(grp0), 0);
        check("rst_wrap", 32'(wrap0), 0);
        check("rst_full", 32'(full0), 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;

        // Test 1: count to 7, then async reset between edges
        enable = 1'b1;
        up_down = 1'b1;
        repeat (7) tick();
        check("t1_count7", 32'(cnt0), 7);
        #2 reset = 1'b0;
        #1;
        check("t1_async_count", 32'(cnt0), 0);
        check("t1_async_groups", 32'(grp0), 0);
        check("t1_async_wrap", 32'(wrap0), 0);
        enable = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;

        // Test 2: 12 up events wrap once
        enable = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            tick();
            check("t2_count", 32'(cnt0), 32'(i));
            check("t2_nowrap", 32'(wrap0), 0);
        end
        tick();
        check("t2_wrap_count", 32'(cnt0), 0);
        check("t2_wrap", 32'(wrap0), 1);
        check("t2_groups", 32'(grp0), 1);
        check("t2_sat_count", 32'(cnt2), 11);
        check("t2_sat_wrap", 32'(wrap2), 0);
        enable = 1'b0;
        tick();
        check("t2_wrap_drop", 32'(wrap0), 0);
        check("t2_hold_count", 32'(cnt0), 0);
        check("t2_hold_groups", 32'(grp0), 1);

        // Test 3: down wraps, groups floor at 0
        enable = 1'b1;
        up_down = 1'b0;
        tick();
        check("t3_down_count", 32'(cnt0), 11);
        check("t3_down_groups", 32'(grp0), 0);
        check("t3_down_wrap", 32'(wrap0), 1);
        check("t3_sat_down", 32'(cnt2), 10);
        enable = 1'b0;
        load = 1'b1;
        load_value = 4'd0;
        tick();
        check("t3_load0", 32'(cnt0), 0);
        check("t3_load_wrap", 32'(wrap0), 0);
        load = 1'b0;
        enable = 1'b1;
        tick();
        check("t3_down2_count", 32'(cnt0), 11);
        check("t3_down2_groups", 32'(grp0), 0);
        check("t3_down2_wrap", 32'(wrap0), 1);
        check("t3_sat_floor", 32'(cnt2), 0);

        // Test 4: load beats enable, clamps; clear beats load
        up_down = 1'b1;
        load = 1'b1;
        load_value = 4'd5;
        tick();
        check("t4_load5", 32'(cnt0), 5);
        check("t4_load5_wrap", 32'(wrap0), 0);
        load_value = 4'd14;
        tick();
        check("t4_load14", 32'(cnt0), 11);
        check("t4_load14_sat", 32'(cnt2), 11);
        clear = 1'b1;
        tick();
        check("t4_clear_count", 32'(cnt0), 0);
        check("t4_clear_groups", 32'(grp0), 0);
        clear = 1'b0;
        load = 1'b0;

        // Test 5: 2-bit group counter saturates at 3
        for (int i = 1; i <= 48; i++) begin
            tick();
            if (i == 36) begin
                check("t5_groups36", 32'(grp1), 3);
                check("t5_full36", 32'(full1), 1);
                check("t5_wrap36", 32'(wrap1), 1);
            end
            if (i == 47) begin
                check("t5_count47", 32'(cnt1), 11);
                check("t5_wrap47", 32'(wrap1), 0);
            end
        end
        check("t5_count48", 32'(cnt1), 0);
        check("t5_wrap48", 32'(wrap1), 1);
        check("t5_groups48", 32'(grp1), 3);
        check("t5_full48", 32'(full1), 1);
        check("t5_wide_groups", 32'(grp0), 4);
        check("t5_wide_full", 32'(full0), 0);

        // Test 6: saturate build clamps both ends, never wraps
        enable = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        enable = 1'b1;
        up_down = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            check("t6_up_nowrap", 32'(wrap2), 0);
        end
        check("t6_up_count", 32'(cnt2), 11);
        check("t6_up_groups", 32'(grp2), 0);
        up_down = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            check("t6_dn_nowrap", 32'(wrap2), 0);
        end
        check("t6_dn_count", 32'(cnt2), 0);
        check("t6_dn_groups", 32'(grp2), 0);
        enable = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
